reservation_alu1_scheduler: RTL and testbench

Control block for a 4-entry ALU1 reservation station built from `reservation_alu1_entry` instances. It picks a free entry for each dispatched instruction, tracks entry age, and issues the oldest operand-ready entry to the ALU1 execution unit. On a pipeline flush it broadcasts a remove to every entry. It carries no operand data: the upper level routes the register and info buses using the entry indices this block produces.

---
 rtl/reservation_alu1_scheduler_if.sv | 40 ++++
 rtl/reservation_alu1_scheduler.sv | 115 +++++++++++
 tb/tb_reservation_alu1_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/reservation_alu1_scheduler_if.sv
`timescale 1ns/1ps
// reservation_alu1_scheduler_if
// Handshake and control bus between the ALU1 reservation-station scheduler,
// its four entries and the issue port of the ALU1 execution unit.
// Bit i of every 4-bit vector belongs to entry i.
//   slave  : the scheduler side (consumes i* signals, drives o* signals)
//   master : the surrounding pipeline / entries side
interface reservation_alu1_scheduler_if;
    logic        iFLUSH;
    logic        iDISPATCH_VALID;
    logic        oDISPATCH_LOCK;
    logic [1:0]  oDISPATCH_ENTRY;
    logic [3:0]  oENTRY_REGISTER_VALID;
    logic [3:0]  oENTRY_REMOVE_VALID;
    logic [3:0]  oENTRY_EXOUT_VALID;
    logic [3:0]  iENTRY_VALID;
    logic [3:0]  iENTRY_MATCHING;
    logic [3:0]  iENTRY_REGIST_LOCK;
    logic        iEXE_LOCK;
    logic        oEXE_VALID;
    logic [1:0]  oEXE_ENTRY;
    logic [2:0]  oFREE_COUNT;
    logic [15:0] oISSUE_COUNT;

    modport slave (
        input  iFLUSH, iDISPATCH_VALID, iENTRY_VALID, iENTRY_MATCHING,
               iENTRY_REGIST_LOCK, iEXE_LOCK,
        output oDISPATCH_LOCK, oDISPATCH_ENTRY, oENTRY_REGISTER_VALID,
               oENTRY_REMOVE_VALID, oENTRY_EXOUT_VALID, oEXE_VALID,
               oEXE_ENTRY, oFREE_COUNT, oISSUE_COUNT
    );

    modport master (
        output iFLUSH, iDISPATCH_VALID, iENTRY_VALID, iENTRY_MATCHING,
               iENTRY_REGIST_LOCK, iEXE_LOCK,
        input  oDISPATCH_LOCK, oDISPATCH_ENTRY, oENTRY_REGISTER_VALID,
               oENTRY_REMOVE_VALID, oENTRY_EXOUT_VALID, oEXE_VALID,
               oEXE_ENTRY, oFREE_COUNT, oISSUE_COUNT
    );
endinterface

// File: rtl/reservation_alu1_scheduler.sv
`timescale 1ns/1ps
// reservation_alu1_scheduler
// Control for a 4-entry ALU1 reservation station: picks the lowest free entry
// for each dispatch, keeps a pairwise age matrix, and issues the oldest
// operand-ready entry. A flush broadcasts remove to every entry.
// Ports:
//   iCLOCK   : clock, rising edge
//   inRESET  : asynchronous active-low reset
//   bus      : reservation_alu1_scheduler_if.slave (dispatch, entry status,
//              register/remove/exout strobes, issue port, counters)
// Allocation/issue/remove outputs are combinational from the current inputs
// and the registered alloc_pend/age/issue_cnt state.
module reservation_alu1_scheduler (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    reservation_alu1_scheduler_if.slave   bus
);
    localparam int unsigned ENTRY_N = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned FREE_W  = 3;
    localparam int unsigned CNT_W   = 16;

    logic [ENTRY_N-1:0]              alloc_pend;
    logic [ENTRY_N-1:0][ENTRY_N-1:0] age;       // age[i][j]: entry i older than entry j
    logic [ENTRY_N-1:0][ENTRY_N-1:0] age_nxt;
    logic [CNT_W-1:0]                issue_cnt;

    logic [ENTRY_N-1:0] free;
    logic [ENTRY_N-1:0] live;
    logic [ENTRY_N-1:0] ready;
    logic [ENTRY_N-1:0] candidate;
    logic [ENTRY_N-1:0] pick;
    logic [ENTRY_N-1:0] reg_oh;
    logic [ENTRY_N-1:0] exout_oh;
    logic [IDX_W-1:0]   disp_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic [FREE_W-1:0]  free_cnt;
    logic               disp_lock;
    logic               accept;
    logic               fire;

    // Allocation: alloc_pend hides an entry until its own lock becomes visible.
    always_comb begin
        free     = ~bus.iENTRY_VALID & ~bus.iENTRY_REGIST_LOCK & ~alloc_pend;
        disp_idx = '0;
        free_cnt = '0;
        for (int i = ENTRY_N - 1; i >= 0; i--) begin
            if (free[i]) disp_idx = IDX_W'(i);
            free_cnt = free_cnt + FREE_W'(free[i]);
        end
        disp_lock = bus.iFLUSH | (free == '0);
        accept    = bus.iDISPATCH_VALID & ~disp_lock;
        reg_oh    = accept ? (ENTRY_N'(1) << disp_idx) : '0;
    end

    // Issue select: a ready entry wins when no other ready entry is older.
    // If the matrix is ever inconsistent, fall back to all ready entries so the
    // lowest index still wins.
    always_comb begin
        ready     = bus.iENTRY_VALID & bus.iENTRY_MATCHING;
        candidate = ready;
        for (int i = 0; i < ENTRY_N; i++) begin
            for (int j = 0; j < ENTRY_N; j++) begin
                if ((i != j) && ready[j] && age[j][i]) candidate[i] = 1'b0;
            end
        end
        pick      = (candidate != '0) ? candidate : ready;
        grant_idx = '0;
        for (int i = ENTRY_N - 1; i >= 0; i--) begin
            if (pick[i]) grant_idx = IDX_W'(i);
        end
        fire     = (ready != '0) & ~bus.iEXE_LOCK & ~bus.iFLUSH;
        exout_oh = fire ? (ENTRY_N'(1) << grant_idx) : '0;
    end

    // Age update: the newly registered entry becomes younger than every live entry.
    always_comb begin
        live    = bus.iENTRY_VALID | alloc_pend;
        age_nxt = age;
        if (accept) begin
            for (int j = 0; j < ENTRY_N; j++) begin
                age_nxt[disp_idx][j] = 1'b0;
                if ((IDX_W'(j) != disp_idx) && live[j]) age_nxt[j][disp_idx] = 1'b1;
            end
        end
    end

    // State registers; flush clears allocation tracking but keeps the issue count.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            alloc_pend <= '0;
            age        <= '0;
            issue_cnt  <= '0;
        end else begin
            if (fire) issue_cnt <= issue_cnt + CNT_W'(1);
            if (bus.iFLUSH) begin
                alloc_pend <= '0;
                age        <= '0;
            end else begin
                alloc_pend <= reg_oh;
                age        <= age_nxt;
            end
        end
    end

    assign bus.oDISPATCH_LOCK        = disp_lock;
    assign bus.oDISPATCH_ENTRY       = disp_idx;
    assign bus.oENTRY_REGISTER_VALID = reg_oh;
    assign bus.oENTRY_REMOVE_VALID   = {ENTRY_N{bus.iFLUSH}};
    assign bus.oENTRY_EXOUT_VALID    = exout_oh;
    assign bus.oEXE_VALID            = fire;
    assign bus.oEXE_ENTRY            = grant_idx;
    assign bus.oFREE_COUNT           = free_cnt;
    assign bus.oISSUE_COUNT          = issue_cnt;
endmodule

// File: tb/tb_reservation_alu1_scheduler.sv
`timescale 1ns/1ps
// tb_reservation_alu1_scheduler
// Self-checking bench: a behavioural model of the four entries and of the
// scheduler rules (allocation-order queue for age, plain counters) drives the
// entry status inputs and predicts every scheduler output each cycle.
module tb_reservation_alu1_scheduler;
    logic iCLOCK = 1'b0;
    logic inRESET;

    reservation_alu1_scheduler_if bus ();

    reservation_alu1_scheduler dut (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .bus    (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b1;

    // Reference state: entry status seen by the scheduler, allocation order.
    bit [3:0]  m_valid, m_lock, m_pend, m_match;
    int        m_order[$];          // live entries, oldest first
    bit [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = '0; m_lock = '0; m_pend = '0; m_match = '0;
        m_order.delete();
        m_cnt = '0;
    endtask

    // Reset (also usable mid-run): checks reset values, then releases reset.
    task automatic reset_check();
        inRESET = 1'b0;
        model_clear();
        bus.iFLUSH = 1'b0; bus.iDISPATCH_VALID = 1'b0; bus.iEXE_LOCK = 1'b0;
        bus.iENTRY_VALID = '0; bus.iENTRY_MATCHING = '0; bus.iENTRY_REGIST_LOCK = '0;
        #1;
        chk("rst_dispatch_lock",  bus.oDISPATCH_LOCK, 0);
        chk("rst_dispatch_entry", bus.oDISPATCH_ENTRY, 0);
        chk("rst_free_count",     bus.oFREE_COUNT, 4);
        chk("rst_exe_valid",      bus.oEXE_VALID, 0);
        chk("rst_register",       bus.oENTRY_REGISTER_VALID, 0);
        chk("rst_remove",         bus.oENTRY_REMOVE_VALID, 0);
        chk("rst_exout",          bus.oENTRY_EXOUT_VALID, 0);
        chk("rst_issue_count",    bus.oISSUE_COUNT, 0);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        @(posedge iCLOCK);
        #1;
    endtask

    // One clock cycle: drive inputs, predict, compare at negedge, advance model.
    task automatic cycle(input bit disp, input bit fl, input bit el);
        bit [3:0] free, ready, e_reg, e_exout, new_valid;
        bit [1:0] e_entry, e_grant;
        bit       e_lock, e_accept, e_fire;
        int       g;
        bus.iDISPATCH_VALID    = disp;
        bus.iFLUSH             = fl;
        bus.iEXE_LOCK          = el;
        bus.iENTRY_VALID       = m_valid;
        bus.iENTRY_REGIST_LOCK = m_lock;
        bus.iENTRY_MATCHING    = m_match;

        free    = ~m_valid & ~m_lock & ~m_pend;
        e_entry = 2'd0;
        for (int i = 3; i >= 0; i--) if (free[i]) e_entry = 2'(i);
        e_lock   = fl || (free == 4'h0);
        e_accept = disp && !e_lock;
        e_reg    = e_accept ? 4'(1 << e_entry) : 4'h0;

        ready = m_valid & m_match;
        g = -1;
        foreach (m_order[k]) if (g < 0 && ready[m_order[k]]) g = m_order[k];
        e_fire  = (g >= 0) && !el && !fl;
        e_grant = (g >= 0) ? 2'(g) : 2'd0;
        e_exout = e_fire ? 4'(1 << g) : 4'h0;

        @(negedge iCLOCK);
        if (chk_en) begin
            chk("dispatch_lock",  bus.oDISPATCH_LOCK, e_lock);
            chk("dispatch_entry", bus.oDISPATCH_ENTRY, e_entry);
            chk("register_valid", bus.oENTRY_REGISTER_VALID, e_reg);
            chk("remove_valid",   bus.oENTRY_REMOVE_VALID, fl ? 4'hF : 4'h0);
            chk("exout_valid",    bus.oENTRY_EXOUT_VALID, e_exout);
            chk("exe_valid",      bus.oEXE_VALID, e_fire);
            chk("exe_entry",      bus.oEXE_ENTRY, e_grant);
            chk("free_count",     bus.oFREE_COUNT, $countones(free));
            chk("issue_count",    bus.oISSUE_COUNT, m_cnt);
        end
        @(posedge iCLOCK);
        #1;

        if (fl) begin
            // Removed entries stay locked for one cycle, then become free.
            m_valid = '0; m_lock = 4'hF; m_pend = '0; m_match = '0;
            m_order.delete();
        end else begin
            new_valid = (m_valid & ~e_exout) | e_reg;
            m_lock    = new_valid | e_exout;
            m_valid   = new_valid;
            m_pend    = e_reg;
            m_match   = m_match & ~e_exout & ~e_reg;
            if (e_fire) begin
                m_cnt = m_cnt + 16'd1;
                for (int k = 0; k < m_order.size(); k++) begin
                    if (m_order[k] == g) begin
                        m_order.delete(k);
                        break;
                    end
                end
            end
            if (e_accept) m_order.push_back(int'(e_entry));
        end
    endtask

    initial begin
        reset_check();

        // Fill: entries 0..3 in order, then dispatch is locked.
        repeat (5) cycle(1'b1, 1'b0, 1'b0);

        // Oldest-first: e2 ready first (held by a stall), then e0; e0 issues first.
        m_match[2] = 1'b1; cycle(1'b0, 1'b0, 1'b1);
        m_match[0] = 1'b1; cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Stall: e3 ready while the ALU is locked for three cycles.
        m_match[3] = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Flush with three valid entries and a dispatch pending.
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Reuse: e1 exits while e3 is allocated, is blocked next cycle, reused after.
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        m_match[1] = 1'b1; cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        m_match = 4'hF;
        repeat (6) cycle(1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            m_match = m_match | (m_valid & 4'($urandom_range(0, 15)));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 3) == 0);
        end

        // Wrap: issue back-to-back until the counter reaches 16'hFFFF.
        chk_en = 1'b0;
        for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) begin
            m_match = 4'hF;
            cycle(1'b1, 1'b0, 1'b0);
        end
        chk_en = 1'b1;
        m_match = 4'hF;
        cycle(1'b0, 1'b0, 1'b0);
        chk("wrap_zero", bus.oISSUE_COUNT, 16'h0);
        cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset_check();
        for (int n = 0; n < 40; n++) begin
            m_match = m_match | (m_valid & 4'($urandom_range(0, 15)));
            cycle($urandom_range(0, 1) != 0, 1'b0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
